// File: rtl/nco_pkg.sv
// rtl/nco_pkg.sv - mode encodings and reset increment shared by the NCO bank
package nco_pkg;
   typedef enum logic [1:0] {
      MODE_HOLD  = 2'd0,
      MODE_STEP  = 2'd1,
      MODE_GLIDE = 2'd2,
      MODE_RSVD  = 2'd3
   } mode_e;

   localparam int DEF_INC = 358;
endpackage

// File: rtl/nco_channel.sv
// rtl/nco_channel.sv - one phase accumulator with tick, step/glide increment tracking and lock flag
module nco_channel
   import nco_pkg::*;
#(
   parameter int ACC_W      = 32,
   parameter int INC_W      = 16,
   parameter int GLIDE_RATE = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       mode,
   input  logic             sync,
   input  logic [INC_W-1:0] target,
   output logic [INC_W-1:0] cur_inc,
   output logic             nco_out,
   output logic             tick,
   output logic             locked
);
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [INC_W-1:0] cur_inc_q, cur_inc_d;
   logic             tick_q, tick_d;
   logic             locked_q, locked_d;
   logic [INC_W-1:0] diff, stride;

   always_comb begin
      acc_d    = sync ? '0 : acc_q + ACC_W'(cur_inc_q);
      // a sync-forced zero never produces a rising MSB, so it cannot tick
      tick_d   = ~acc_q[ACC_W-1] & acc_d[ACC_W-1];
      locked_d = (cur_inc_q == target);
      diff     = (target > cur_inc_q) ? target - cur_inc_q : cur_inc_q - target;
      stride   = (diff > INC_W'(GLIDE_RATE)) ? INC_W'(GLIDE_RATE) : diff;
      cur_inc_d = cur_inc_q;
      case (mode_e'(mode))
         MODE_STEP:  cur_inc_d = target;
         MODE_GLIDE: cur_inc_d = (target > cur_inc_q) ? cur_inc_q + stride : cur_inc_q - stride;
         default:    cur_inc_d = cur_inc_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q     <= '0;
         cur_inc_q <= INC_W'(DEF_INC);
         tick_q    <= 1'b0;
         locked_q  <= 1'b1;
      end else begin
         acc_q     <= acc_d;
         cur_inc_q <= cur_inc_d;
         tick_q    <= tick_d;
         locked_q  <= locked_d;
      end
   end

   assign cur_inc = cur_inc_q;
   assign nco_out = acc_q[ACC_W-1];
   assign tick    = tick_q;
   assign locked  = locked_q;
endmodule

// File: rtl/nco_bank.sv
// rtl/nco_bank.sv - bank of NCO channels sharing a dwell timer, preset index and preset table
module nco_bank
   import nco_pkg::*;
#(
   parameter int NUM_CH      = 3,
   parameter int ACC_W       = 32,
   parameter int INC_W       = 16,
   parameter int NUM_PRESETS = 4,
   parameter int STEP_W      = 25,
   parameter int GLIDE_RATE  = 8,
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int IDX_W = (NUM_PRESETS > 1) ? $clog2(NUM_PRESETS) : 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        mode,
   input  logic [STEP_W-1:0] step_max,
   input  logic              sync,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [IDX_W-1:0]  cfg_idx,
   input  logic [INC_W-1:0]  cfg_inc,
   output logic [NUM_CH-1:0] nco_out,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] locked,
   output logic [IDX_W-1:0]  preset_idx,
   output logic              update
);
   logic [STEP_W-1:0] timer_q, timer_d;
   logic [IDX_W-1:0]  preset_idx_q, preset_idx_d;
   logic              update_q, update_d;
   logic              cfg_ready_q, cfg_ready_d;
   logic [INC_W-1:0]  table_q [NUM_CH][NUM_PRESETS];
   logic [INC_W-1:0]  table_d [NUM_CH][NUM_PRESETS];
   logic [INC_W-1:0]  target  [NUM_CH];
   logic [INC_W-1:0]  cur_inc [NUM_CH];
   logic              running, advance, cfg_wr;

   always_comb begin
      running = ((mode_e'(mode) == MODE_STEP) || (mode_e'(mode) == MODE_GLIDE)) && (step_max != '0);
      // equality only: a lowered step_max lets the timer roll over instead of advancing early
      advance = running && (timer_q == step_max - STEP_W'(1));
      timer_d      = timer_q;
      preset_idx_d = preset_idx_q;
      update_d     = advance;
      cfg_ready_d  = 1'b1;
      if (running)
         timer_d = advance ? '0 : timer_q + STEP_W'(1);
      if (advance)
         preset_idx_d = (preset_idx_q == IDX_W'(NUM_PRESETS - 1)) ? '0 : preset_idx_q + IDX_W'(1);
      cfg_wr  = cfg_valid & cfg_ready_q;
      table_d = table_q;
      for (int c = 0; c < NUM_CH; c++)
         for (int i = 0; i < NUM_PRESETS; i++)
            if (cfg_wr && (cfg_ch == CH_W'(c)) && (cfg_idx == IDX_W'(i)))
               table_d[c][i] = cfg_inc;
   end

   always_comb begin
      for (int c = 0; c < NUM_CH; c++)
         target[c] = table_q[c][preset_idx_q];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         timer_q      <= '0;
         preset_idx_q <= '0;
         update_q     <= 1'b0;
         cfg_ready_q  <= 1'b0;
         for (int c = 0; c < NUM_CH; c++)
            for (int i = 0; i < NUM_PRESETS; i++)
               table_q[c][i] <= INC_W'(DEF_INC << i);
      end else begin
         timer_q      <= timer_d;
         preset_idx_q <= preset_idx_d;
         update_q     <= update_d;
         cfg_ready_q  <= cfg_ready_d;
         table_q      <= table_d;
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      nco_channel #(
         .ACC_W      (ACC_W),
         .INC_W      (INC_W),
         .GLIDE_RATE (GLIDE_RATE)
      ) u_ch (
         .clk     (clk),
         .reset_n (reset_n),
         .mode    (mode),
         .sync    (sync),
         .target  (target[c]),
         .cur_inc (cur_inc[c]),
         .nco_out (nco_out[c]),
         .tick    (tick[c]),
         .locked  (locked[c])
      );
   end

   assign cfg_ready  = cfg_ready_q;
   assign preset_idx = preset_idx_q;
   assign update     = update_q;
endmodule

// File: tb/tb_nco_bank.sv
// tb/tb_nco_bank.sv - scoreboard bench for nco_bank with directed, hand-computed expectations
module tb_nco_bank;
   import nco_pkg::*;

   localparam int NUM_CH = 3, ACC_W = 16, INC_W = 16, NUM_PRESETS = 4, STEP_W = 8, GLIDE_RATE = 8;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [1:0]        mode;
   logic [STEP_W-1:0] step_max;
   logic              sync;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [1:0]        cfg_ch;
   logic [1:0]        cfg_idx;
   logic [INC_W-1:0]  cfg_inc;
   logic [NUM_CH-1:0] nco_out, tick, locked;
   logic [1:0]        preset_idx;
   logic              update;

   nco_bank #(
      .NUM_CH(NUM_CH), .ACC_W(ACC_W), .INC_W(INC_W), .NUM_PRESETS(NUM_PRESETS),
      .STEP_W(STEP_W), .GLIDE_RATE(GLIDE_RATE)
   ) dut (
      .clk(clk), .reset_n(reset_n), .mode(mode), .step_max(step_max), .sync(sync),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_idx(cfg_idx),
      .cfg_inc(cfg_inc), .nco_out(nco_out), .tick(tick), .locked(locked),
      .preset_idx(preset_idx), .update(update)
   );

   always #5 clk = ~clk;

   typedef struct { int cyc; int sel; int exp; string name; } chk_t;
   typedef struct { int cyc; int idx; } upd_t;
   chk_t chk_q[$];
   upd_t upd_q[$];
   int total = 0, bad = 0, cyc = 0;
   logic [NUM_CH-1:0] prev_out = '0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_at(input int c, input int sel, input int exp, input string name);
      chk_q.push_back('{c, sel, exp, name});
   endtask

   task automatic expect_upd(input int c, input int idx);
      upd_q.push_back('{c, idx});
   endtask

   function automatic int actual(input int sel);
      case (sel)
         0:       return int'(cfg_ready);
         1:       return int'(preset_idx);
         2:       return int'(locked);
         3:       return int'(dut.cur_inc[0]);
         4:       return int'(dut.cur_inc[1]);
         5:       return int'(dut.cur_inc[2]);
         6:       return int'(tick[2]);
         7:       return int'(nco_out[2]);
         default: return -1;
      endcase
   endfunction

   task automatic goto(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      if (!reset_n) begin
         prev_out = '0;
      end else begin
         check("tick_vs_edge", int'(tick), int'(nco_out & ~prev_out));
         prev_out = nco_out;
         for (int i = chk_q.size() - 1; i >= 0; i--) begin
            if (chk_q[i].cyc == cyc) begin
               check(chk_q[i].name, actual(chk_q[i].sel), chk_q[i].exp);
               chk_q.delete(i);
            end
         end
         if (update) begin
            if (upd_q.size() == 0) begin
               check("no_update", int'(update), 0);
            end else begin
               check("update_cyc", cyc, upd_q[0].cyc);
               check("update_idx", int'(preset_idx), upd_q[0].idx);
               void'(upd_q.pop_front());
            end
         end
      end
   end

   task automatic check_reset_values();
      check("rst_cfg_ready", int'(cfg_ready), 0);
      check("rst_preset_idx", int'(preset_idx), 0);
      check("rst_update", int'(update), 0);
      check("rst_tick", int'(tick), 0);
      check("rst_locked", int'(locked), 7);
      check("rst_nco_out", int'(nco_out), 0);
      check("rst_cur_inc0", int'(dut.cur_inc[0]), 358);
      check("rst_cur_inc1", int'(dut.cur_inc[1]), 358);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      mode = MODE_HOLD; step_max = 24; sync = 0;
      cfg_valid = 0; cfg_ch = 0; cfg_idx = 0; cfg_inc = 0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_values();
      mode = MODE_STEP;
      reset_n = 1'b1;
      expect_at(0, 0, 0, "cfg_ready_first");
      expect_at(1, 0, 1, "cfg_ready_after");
      expect_at(1, 3, 358, "step_cur0_start");
      expect_at(24, 3, 358, "step_cur0_c24");
      expect_at(25, 3, 716, "step_cur0_c25");
      expect_at(49, 3, 1432, "step_cur0_c49");
      expect_at(73, 3, 2864, "step_cur0_c73");
      expect_at(97, 3, 358, "step_cur0_c97");
      expect_upd(24, 1); expect_upd(48, 2); expect_upd(72, 3); expect_upd(96, 0);

      goto(100);
      mode = MODE_HOLD;
      expect_at(150, 1, 0, "hold_idx_c150");
      expect_at(150, 3, 358, "hold_cur0_c150");
      expect_at(200, 1, 0, "hold_idx_c200");
      expect_at(200, 3, 358, "hold_cur0_c200");

      goto(200);
      mode = MODE_STEP; step_max = 0;
      expect_at(250, 1, 0, "stepmax0_idx");
      expect_at(250, 3, 358, "stepmax0_cur0");

      goto(250);
      mode = MODE_GLIDE; step_max = 24;
      expect_upd(270, 1);
      expect_at(270, 2, 7, "glide_locked_c270");
      expect_at(271, 2, 0, "glide_locked_c271");
      expect_at(271, 3, 366, "glide_cur0_c271");
      expect_at(314, 3, 710, "glide_cur0_c314");
      expect_at(315, 3, 716, "glide_cur0_c315");
      expect_at(315, 4, 716, "glide_cur1_c315");
      expect_at(315, 2, 0, "glide_locked_c315");
      expect_at(316, 2, 7, "glide_locked_c316");

      goto(270);
      step_max = 200;

      goto(320);
      mode = MODE_STEP;
      cfg_valid = 1; cfg_ch = 2; cfg_idx = 1; cfg_inc = 16'h8000;
      expect_at(322, 5, 32768, "step_cur2_write");
      goto(321);
      cfg_valid = 0;

      goto(330);
      sync = 1;
      expect_at(331, 7, 0, "sync_nco2");
      expect_at(331, 6, 0, "sync_tick2");
      expect_at(332, 6, 1, "tick2_c332");
      expect_at(333, 6, 0, "tick2_c333");
      expect_at(334, 6, 1, "tick2_c334");
      goto(331);
      sync = 0;

      goto(340);
      mode = MODE_GLIDE;
      cfg_valid = 1; cfg_ch = 1; cfg_idx = 1; cfg_inc = 16'd1000;
      expect_at(342, 4, 724, "ramp_cur1_c342");
      expect_at(343, 4, 732, "ramp_cur1_c343");
      expect_at(344, 4, 1000, "snap_cur1_c344");
      goto(341);
      cfg_valid = 0;
      goto(343);
      mode = MODE_STEP;

      goto(400);
      step_max = 100;
      expect_at(525, 1, 1, "rollover_idx_c525");
      expect_at(600, 1, 1, "rollover_idx_c600");
      expect_upd(626, 2);

      goto(625);
      cfg_valid = 1; cfg_ch = 1; cfg_idx = 2; cfg_inc = 16'd1000;
      expect_at(627, 4, 1000, "wr_adv_cur1");
      expect_at(629, 3, 1432, "drop_cur0");
      expect_at(629, 4, 1000, "drop_cur1");
      expect_at(629, 5, 1432, "drop_cur2");
      goto(626);
      cfg_ch = 3; cfg_idx = 2; cfg_inc = 16'd5;
      goto(627);
      cfg_valid = 0;

      goto(640);
      mode = MODE_GLIDE;
      cfg_valid = 1; cfg_ch = 0; cfg_idx = 2; cfg_inc = 16'd3000;
      expect_at(642, 3, 1440, "glide2_cur0_c642");
      expect_at(645, 3, 1464, "glide2_cur0_c645");
      goto(641);
      cfg_valid = 0;

      goto(646);
      reset_n = 1'b0;
      #1;
      check_reset_values();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      expect_at(0, 0, 0, "rel_cfg_ready_first");
      expect_at(1, 0, 1, "rel_cfg_ready_after");
      expect_at(1, 3, 358, "rel_cur0");
      expect_at(1, 2, 7, "rel_locked");
      expect_at(3, 1, 0, "rel_idx");

      goto(10);
      check("pending_checks", chk_q.size(), 0);
      check("pending_updates", upd_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/nco_bank.md
NCO_BANK -- requirements
Module: nco_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, number of independent NCO channels.
REQ-002 SHALL have parameter ACC_W, default 32, phase accumulator width.
REQ-003 SHALL have parameter INC_W, default 16, increment width (INC_W <= ACC_W).
REQ-004 SHALL have parameter NUM_PRESETS, default 4, preset table depth per channel (power of 2).
REQ-005 SHALL have parameter STEP_W, default 25, step-interval counter width.
REQ-006 SHALL have parameter GLIDE_RATE, default 8, max increment change per cycle in glide mode.
REQ-007 SHALL have port clk, input, 1, clock; rising edge.
REQ-008 SHALL have port reset_n, input, 1, asynchronous reset, active-low.
REQ-009 SHALL have port mode, input, 2, 0=HOLD, 1=STEP, 2=GLIDE, 3=reserved (treated as HOLD).
REQ-010 SHALL have port step_max, input, STEP_W, preset dwell in cycles; 0 freezes the timer.
REQ-011 SHALL have port sync, input, 1, synchronous zeroing of all accumulators.
REQ-012 SHALL have ports cfg_valid (input, 1), cfg_ready (output, 1), cfg_ch (input, clog2(NUM_CH)), cfg_idx (input, clog2(NUM_PRESETS)), and cfg_inc (input, INC_W), forming the preset-write handshake.
REQ-013 SHALL have port nco_out, output, NUM_CH, accumulator MSB per channel.
REQ-014 SHALL have port tick, output, NUM_CH, one-cycle pulse per nco_out rising edge.
REQ-015 SHALL have port locked, output, NUM_CH, current increment equal to target.
REQ-016 SHALL have ports preset_idx (output, clog2(NUM_PRESETS)) and update (output, 1), giving the active preset and a one-cycle advance pulse.

Function
REQ-017 Each cycle, acc[c] SHALL become (acc[c] + zero-extended cur_inc[c]) mod 2^ACC_W; when sync=1, acc[c] SHALL become 0 and sync SHALL win.
REQ-018 tick[c] SHALL be registered and SHALL be 1 in the cycle after acc[c] MSB changes 0->1; sync-induced 1->0 SHALL NOT tick.
REQ-019 In STEP/GLIDE with step_max>0, the timer SHALL count 0..step_max-1; at terminal count it SHALL return to 0, preset_idx SHALL advance (wrapping NUM_PRESETS-1 -> 0), and update SHALL be 1 for exactly that next cycle.
REQ-020 If step_max is lowered below the current timer value, the timer SHALL reach the terminal count via a rollover through 2^STEP_W-1, with no early advance.
REQ-021 In HOLD, or with step_max=0, the timer and preset_idx SHALL hold and update SHALL stay 0.
REQ-022 target[c] SHALL equal table[c][preset_idx].
REQ-023 In STEP, cur_inc[c] SHALL load target[c] one cycle after any preset_idx change or table write.
REQ-024 In GLIDE, cur_inc[c] SHALL move toward target[c] by min(GLIDE_RATE, |target-cur|) per cycle, with no overshoot.
REQ-025 In HOLD, cur_inc SHALL hold.
REQ-026 locked[c] SHALL be registered as (cur_inc[c]==target[c]).
REQ-027 cfg_ready SHALL be 1 at all times except in the first cycle after reset release; a write SHALL occur on a cycle where cfg_valid & cfg_ready.
REQ-028 A write with cfg_ch >= NUM_CH SHALL be dropped.
REQ-029 When a table write and a preset advance occur in the same cycle, the write SHALL commit first, and the next-cycle target SHALL use the written value if the indices match.
REQ-030 A mode change SHALL take effect on the next clock edge; switching GLIDE->STEP mid-ramp SHALL snap cur_inc to target one cycle later.

Reset
REQ-031 On reset_n=0, the block SHALL asynchronously force: all acc=0, cur_inc[c]=DEF_INC, table[c][i]=DEF_INC<<i, timer=0, preset_idx=0, update=0, tick=0, locked=all 1, cfg_ready=0.
REQ-032 Reset assertion mid-glide or mid-interval SHALL discard all progress; the first accumulation SHALL occur on the first edge after release.

Structure
REQ-033 Package nco_pkg SHALL hold the mode encodings (MODE_HOLD, MODE_STEP, MODE_GLIDE) and DEF_INC=358.
REQ-034 Sub-module nco_channel (accumulator, tick, glide/step increment, locked) SHALL be instantiated NUM_CH times; the timer, preset index, and table SHALL stay in the top level.

Verification
REQ-035 Reset release, mode=STEP, step_max=24 -> update pulses at cycles 24, 48, 72, 96; preset_idx sequence 1,2,3,0; cur_inc[0] = 716, 1432, 2864, 358, each one cycle after its update.
REQ-036 mode=GLIDE, GLIDE_RATE=8, target jump 358->716 -> cur_inc rises by 8 per cycle, reaches 716 after 45 cycles (last step 6); locked rises one cycle later.
REQ-037 Increment 0x8000 with ACC_W=16 -> tick every 2 cycles; assert sync for 1 cycle -> acc=0, no spurious tick.
REQ-038 cfg write (ch=1, idx=preset_idx, inc=1000) in the same cycle as an advance to that idx -> target[1]=1000 next cycle; a write with cfg_ch=3 with NUM_CH=3 -> table unchanged.
REQ-039 mode=HOLD for 100 cycles -> preset_idx and cur_inc constant, update=0; step_max=0 in STEP -> same.
REQ-040 reset_n pulsed low mid-glide -> all outputs at reset values within the same cycle, cfg_ready=0 for one cycle after release.
